mem_sort_checker: RTL and testbench

MEM_SORT_CHECKER -- requirements
Module: mem_sort_checker

---
 rtl/mem_sort_checker.sv | 124 ++++++++++++
 tb/tb_mem_sort_checker.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_sort_checker.sv
// mem_sort_checker: after the CPU halts (or a timeout expires), reads N_WORDS words
// from data memory one byte at a time and checks that they are in sorted order.
module mem_sort_checker #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int N_WORDS   = 10,
  parameter int BASE_ADDR = 'h200,
  parameter int MODE      = 1,
  parameter int SIGNED    = 0,
  parameter int TIMEOUT   = 350
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           halt_i,
  output logic                           rd_en,
  output logic [ADDR_W-1:0]              rd_addr,
  input  logic [7:0]                     rd_data,
  output logic                           word_valid,
  output logic [DATA_W-1:0]              word_data,
  output logic [$clog2(N_WORDS):0]       word_idx,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [$clog2(N_WORDS):0]       err_count,
  output logic [$clog2(N_WORDS):0]       first_err_idx,
  output logic                           timed_out
);
  localparam int BYTES = DATA_W / 8;
  localparam int IW    = $clog2(N_WORDS) + 1;
  localparam int BW    = $clog2(BYTES) + 1;
  localparam int CW    = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, WAIT, READ, CHECK, DONE} state_t;

  state_t              state, state_nx;
  logic [IW-1:0]       w;
  logic [BW-1:0]       b;
  logic [CW-1:0]       wait_cnt;
  logic [DATA_W-1:0]   buf_q, prev, word;
  logic                arm, tmo, last_byte, last_word, gt, lt, viol;

  // Top byte of buf_q is never written, so the final byte can be OR-ed in as it arrives.
  assign word      = buf_q | (DATA_W'(rd_data) << (DATA_W - 8));
  assign arm       = start && (state == IDLE || state == DONE);
  assign tmo       = state == WAIT && !halt_i && wait_cnt == CW'(TIMEOUT - 1);
  assign last_byte = b == BW'(BYTES - 1);
  assign last_word = w == IW'(N_WORDS - 1);

  // Order comparison of the freshly assembled word against the previous one.
  always_comb begin
    gt   = SIGNED != 0 ? ($signed(word) > $signed(prev)) : (word > prev);
    lt   = SIGNED != 0 ? ($signed(word) < $signed(prev)) : (word < prev);
    viol = (w != '0) && (MODE != 0 ? gt : lt);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = WAIT;
      WAIT:       if (halt_i || tmo) state_nx = READ;
      READ:       if (last_byte) state_nx = CHECK;
      CHECK:      state_nx = last_word ? DONE : READ;
      default:    state_nx = IDLE;
    endcase
  end

  // Counters, byte assembly and error bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w             <= '0;
      b             <= '0;
      wait_cnt      <= '0;
      buf_q         <= '0;
      prev          <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      timed_out     <= 1'b0;
    end else begin
      if (arm) begin
        w             <= '0;
        b             <= '0;
        wait_cnt      <= '0;
        err_count     <= '0;
        first_err_idx <= '0;
        timed_out     <= 1'b0;
      end
      if (state == WAIT && !halt_i) wait_cnt <= wait_cnt + 1'b1;
      if (tmo) timed_out <= 1'b1;
      if (state == READ) begin
        b <= b + 1'b1;
        if (b != '0) buf_q[8*(int'(b)-1) +: 8] <= rd_data;
      end
      if (state == CHECK) begin
        prev <= word;
        b    <= '0;
        if (!last_word) w <= w + 1'b1;
        if (viol) begin
          err_count <= err_count + 1'b1;
          if (err_count == '0) first_err_idx <= w;
        end
      end
    end
  end

  // State-decoded outputs; data outputs are forced to zero outside their strobe.
  always_comb begin
    rd_en      = state == READ;
    rd_addr    = rd_en ? ADDR_W'(BASE_ADDR) + ADDR_W'(w) * ADDR_W'(BYTES) + ADDR_W'(b) : '0;
    word_valid = state == CHECK;
    word_data  = word_valid ? word : '0;
    word_idx   = word_valid ? w : '0;
    busy       = state == WAIT || state == READ || state == CHECK;
    done       = state == DONE;
    pass       = done && err_count == '0;
  end
endmodule

// File: tb/tb_mem_sort_checker.sv
// tb_mem_sort_checker: directed vectors for four checker configurations sharing one byte memory.
module tb_mem_sort_checker;
  logic clk = 0, rst = 0, start = 0, halt = 0;
  always #5 clk = ~clk;

  logic        rd_en [4];
  logic [11:0] rd_addr [4];
  logic [7:0]  rd_data [4];
  logic        word_valid [4];
  logic [31:0] word_data [4];
  logic [4:0]  word_idx [4], err_count [4], first_err_idx [4];
  logic        busy [4], done [4], pass [4], timed_out [4];

  // 0: descending unsigned, 1: descending with TIMEOUT=100, 2: ascending unsigned, 3: ascending signed
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : gen_dut
      mem_sort_checker #(
        .MODE((g >= 2) ? 0 : 1), .SIGNED((g == 3) ? 1 : 0), .TIMEOUT((g == 1) ? 100 : 350)
      ) u_dut (
        .clk(clk), .rst(rst), .start(start), .halt_i(halt),
        .rd_en(rd_en[g]), .rd_addr(rd_addr[g]), .rd_data(rd_data[g]),
        .word_valid(word_valid[g]), .word_data(word_data[g]), .word_idx(word_idx[g]),
        .busy(busy[g]), .done(done[g]), .pass(pass[g]), .err_count(err_count[g]),
        .first_err_idx(first_err_idx[g]), .timed_out(timed_out[g])
      );
    end
  endgenerate

  logic [7:0] mem [4096];
  always @(posedge clk) for (int i = 0; i < 4; i++) rd_data[i] <= mem[rd_addr[i]];

  typedef struct packed {
    logic [1:0]         inst;
    logic signed [15:0] hd;
    logic               poke;
    logic [9:0][31:0]   w;
    logic               ep;
    logic [4:0]         ee, ef;
    logic               et;
    logic [15:0]        rf;
  } vec_t;

  vec_t vecs [8];
  int total = 0, bad = 0;

  function automatic vec_t mk(int inst, int hd, bit poke, logic [9:0][31:0] w,
                              bit ep, int ee, int ef, bit et, int rf);
    vec_t v;
    v.inst = 2'(inst); v.hd = 16'(hd); v.poke = poke; v.w = w;
    v.ep = ep; v.ee = 5'(ee); v.ef = 5'(ef); v.et = et; v.rf = 16'(rf);
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem(logic [9:0][31:0] w);
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 4; j++) mem['h200 + 4*i + j] = w[i][8*j +: 8];
  endtask

  task automatic do_reset;
    rst = 0;
    tick;
    tick;
    rst = 1;
    tick;
  endtask

  task automatic run_vec(vec_t v);
    int k, rf, nrd, nwv, dbad;
    bit poked;
    int n;
    n = int'(v.inst);
    load_mem(v.w);
    start = 1;
    halt = 0;
    tick;
    start = 0;
    k = 0; rf = -1; nrd = 0; nwv = 0; dbad = 0; poked = 0;
    while (!done[n] && k < 2000) begin
      k++;
      halt = v.hd >= 0 && k - 1 >= v.hd;
      tick;
      start = 0;
      if (rd_en[n]) begin
        nrd++;
        if (rf < 0) rf = k;
      end
      if (word_valid[n]) begin
        if (nwv > 9 || int'(word_idx[n]) != nwv || word_data[n] != v.w[nwv]) dbad++;
        nwv++;
        if (v.poke && !poked) begin
          start = 1;
          poked = 1;
        end
      end
    end
    chk("done", done[n], 1);
    chk("reads", nrd, 40);
    chk("words", nwv, 10);
    chk("word_data", dbad, 0);
    chk("read_entry", rf, int'(v.rf));
    chk("latency", k - rf, 50);
    chk("pass", pass[n], v.ep);
    chk("err_count", err_count[n], v.ee);
    chk("first_err_idx", first_err_idx[n], v.ef);
    chk("timed_out", timed_out[n], v.et);
    halt = 0;
    tick;
    tick;
    tick;
    chk("hold", {done[n], busy[n], rd_en[n], pass[n], err_count[n]}, {3'b100, v.ep, v.ee});
  endtask

  initial begin
    logic [9:0][31:0] desc, err4, asc, dup, zf, sasc;
    bit found;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    desc = {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
    err4 = {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd6, 32'd5, 32'd7, 32'd8, 32'd9};
    asc  = {32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
    dup  = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd3, 32'd2, 32'd1, 32'd1};
    zf   = {{9{32'hFFFF_FFFF}}, 32'h0};
    sasc = {32'd7, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFB};
    vecs[0] = mk(0,  5, 0, desc, 1, 0, 0, 0, 6);
    vecs[1] = mk(0,  5, 0, err4, 0, 1, 4, 0, 6);
    vecs[2] = mk(0,  3, 1, asc,  0, 9, 1, 0, 4);
    vecs[3] = mk(1, -1, 0, desc, 1, 0, 0, 1, 100);
    vecs[4] = mk(2,  2, 0, dup,  1, 0, 0, 0, 3);
    vecs[5] = mk(2,  2, 0, zf,   1, 0, 0, 0, 3);
    vecs[6] = mk(3,  2, 0, zf,   0, 1, 1, 0, 3);
    vecs[7] = mk(3,  2, 0, sasc, 1, 0, 0, 0, 3);

    tick;
    chk("reset_ctl", {rd_en[0], busy[0], done[0], pass[0], word_valid[0], timed_out[0]}, 0);
    chk("reset_cnt", {rd_addr[0], err_count[0], first_err_idx[0], word_idx[0], word_data[0]}, 0);

    for (int i = 0; i < 8; i++) begin
      do_reset;
      run_vec(vecs[i]);
    end

    do_reset;
    start = 1;
    halt = 1;
    tick;
    start = 0;
    chk("start_halt_wait", {busy[0], rd_en[0]}, 2'b10);
    tick;
    chk("start_halt_read", {rd_en[0], rd_addr[0]}, {1'b1, 12'h200});
    halt = 0;

    do_reset;
    load_mem(asc);
    start = 1;
    halt = 1;
    tick;
    start = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick;
      found = rd_en[0] && rd_addr[0] == 12'h210;
    end
    chk("reach_word4", found, 1);
    chk("pre_reset_errs", err_count[0], 3);
    #1 rst = 0;
    halt = 0;
    #1;
    chk("async_ctl", {rd_en[0], busy[0], done[0], pass[0], word_valid[0], timed_out[0]}, 0);
    chk("async_cnt", {rd_addr[0], err_count[0], first_err_idx[0], word_idx[0], word_data[0]}, 0);
    tick;
    rst = 1;
    tick;
    chk("release_rd", {rd_en[0], busy[0]}, 0);
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
